// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I definitions: register-file address/word types plus the
// command set of the register-file debug access controller.
package riscv_32i_defs_pkg;

    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int XLEN        = 32;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [XLEN-1:0]      word_t;

    typedef enum logic [1:0] {
        RF_CMD_READ  = 2'd0,
        RF_CMD_WRITE = 2'd1,
        RF_CMD_CLEAR = 2'd2,
        RF_CMD_DUMP  = 2'd3
    } rf_cmd_op_t;

endpackage

// File: rtl/reg_file_access_ctrl.sv
// Debug/test initiator for the register-file ports: executes READ, WRITE,
// CLEAR and DUMP commands while the core is halted and streams responses.
module reg_file_access_ctrl
    import riscv_32i_defs_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DATA_W   = XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_reg,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_reg_1,
    output logic [ADDR_W-1:0] rd_reg_2,
    input  logic [DATA_W-1:0] rd_data_1,
    input  logic [DATA_W-1:0] rd_data_2
);

    if ((2 ** ADDR_W) != NUM_REGS) begin : g_bad_params
        $error("reg_file_access_ctrl: 2**ADDR_W must equal NUM_REGS");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_CLR,
        S_DMP_RD,
        S_DMP_RSP,
        S_RSP
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    rf_cmd_op_t        op;
    logic              unused;

    assign op        = rf_cmd_op_t'(cmd_op);
    // Held low during reset so every output reads 0 while rst_n is asserted.
    assign cmd_ready = rst_n && (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rd_reg_2  = '0;
    assign unused    = ^rd_data_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            wr_en     <= 1'b0;
            wr_reg    <= '0;
            wr_data   <= '0;
            rd_reg_1  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (op)
                            RF_CMD_READ: begin
                                rd_reg_1 <= cmd_addr;
                                state    <= S_RD;
                            end
                            RF_CMD_WRITE: begin
                                wr_en   <= 1'b1;
                                wr_reg  <= cmd_addr;
                                wr_data <= cmd_data;
                                state   <= S_WR;
                            end
                            RF_CMD_CLEAR: begin
                                // x0 is hardwired, so the sweep starts at x1.
                                cnt     <= ONE;
                                wr_en   <= 1'b1;
                                wr_reg  <= ONE;
                                wr_data <= '0;
                                state   <= S_CLR;
                            end
                            default: begin
                                cnt      <= '0;
                                rd_reg_1 <= '0;
                                state    <= S_DMP_RD;
                            end
                        endcase
                    end
                end

                S_RD: begin
                    rsp_valid <= 1'b1;
                    rsp_addr  <= rd_reg_1;
                    rsp_data  <= rd_data_1;
                    rsp_last  <= 1'b1;
                    rd_reg_1  <= '0;
                    state     <= S_RSP;
                end

                S_WR: begin
                    // Echo what x0 will actually hold, not what was sent.
                    rsp_valid <= 1'b1;
                    rsp_addr  <= wr_reg;
                    rsp_data  <= (wr_reg == '0) ? '0 : wr_data;
                    rsp_last  <= 1'b1;
                    wr_en     <= 1'b0;
                    wr_reg    <= '0;
                    wr_data   <= '0;
                    state     <= S_RSP;
                end

                S_CLR: begin
                    if (cnt == LAST_REG) begin
                        wr_en     <= 1'b0;
                        wr_reg    <= '0;
                        rsp_valid <= 1'b1;
                        rsp_addr  <= cnt;
                        rsp_data  <= '0;
                        rsp_last  <= 1'b1;
                        state     <= S_RSP;
                    end else begin
                        cnt    <= cnt + ONE;
                        wr_reg <= cnt + ONE;
                    end
                end

                S_DMP_RD: begin
                    rsp_valid <= 1'b1;
                    rsp_addr  <= cnt;
                    rsp_data  <= rd_data_1;
                    rsp_last  <= (cnt == LAST_REG);
                    rd_reg_1  <= '0;
                    state     <= S_DMP_RSP;
                end

                S_DMP_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        if (rsp_last) begin
                            rsp_addr <= '0;
                            rsp_data <= '0;
                            cnt      <= '0;
                            state    <= S_IDLE;
                        end else begin
                            cnt      <= cnt + ONE;
                            rd_reg_1 <= cnt + ONE;
                            state    <= S_DMP_RD;
                        end
                    end
                end

                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_addr  <= '0;
                        rsp_data  <= '0;
                        rsp_last  <= 1'b0;
                        cnt       <= '0;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_access_ctrl.sv
// Scoreboard bench for reg_file_access_ctrl with a behavioural register file
// attached to its write/read ports.
module tb_reg_file_access_ctrl;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        cmd_valid = 0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 0;
    logic [4:0]  cmd_addr = 0;
    logic [31:0] cmd_data = 0;
    logic        rsp_valid;
    logic        rsp_ready = 0;
    logic [4:0]  rsp_addr;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        busy;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [4:0]  rd_reg_1;
    logic [4:0]  rd_reg_2;
    logic [31:0] rd_data_1;
    logic [31:0] rd_data_2;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
    } rsp_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          c;
    } wlog_t;

    rsp_t        sb[$];
    wlog_t       wlog[$];
    logic [31:0] rf [32] = '{default: 32'h0};
    logic [31:0] exp_rf [32];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc_g = 0;

    always #5 clk = ~clk;

    assign rd_data_1 = rf[rd_reg_1];
    assign rd_data_2 = rf[rd_reg_2];

    always @(posedge clk) begin
        cyc_g <= cyc_g + 1;
        if (wr_en) begin
            wlog.push_back('{a: wr_reg, d: wr_data, c: cyc_g});
            if (wr_reg != 5'd0) rf[wr_reg] <= wr_data;
        end
    end

    reg_file_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_reg_1(rd_reg_1), .rd_reg_2(rd_reg_2),
        .rd_data_1(rd_data_1), .rd_data_2(rd_data_2)
    );

    // Presents one command and returns 1 ns after the accepting edge.
    task automatic send_cmd(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
        int w = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_data = d;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cmd_accept: cmd_ready=%b, want 1 (op=%0d)", cmd_ready, op);
        end
        @(posedge clk);
        #1;
        cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0;
    endtask

    // Drains n responses against the scoreboard; cycle 1 is the cycle after accept.
    task automatic collect(input int n, input int pct, input int maxcyc,
                           output int first_cyc, output int last_cyc);
        int   got = 0;
        int   cyc = 0;
        bit   held = 0;
        rsp_t hv;
        rsp_t e;
        first_cyc = -1;
        last_cyc  = -1;
        while (got < n && cyc < maxcyc) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || {rsp_addr, rsp_data, rsp_last} !== hv) begin
                    n_err++;
                    $display("FAIL rsp_stable: got v=%b a=%0d d=%h l=%b, want v=1 a=%0d d=%h l=%b",
                             rsp_valid, rsp_addr, rsp_data, rsp_last, hv.a, hv.d, hv.l);
                end
            end
            held = 0;
            rsp_ready = ($urandom_range(99) < pct);
            if (rsp_valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (rsp_ready) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL rsp_unexpected: got a=%0d d=%h l=%b, want no response",
                                 rsp_addr, rsp_data, rsp_last);
                    end else begin
                        e = sb.pop_front();
                        if ({rsp_addr, rsp_data, rsp_last} !== e) begin
                            n_err++;
                            $display("FAIL rsp_fields: got a=%0d d=%h l=%b, want a=%0d d=%h l=%b",
                                     rsp_addr, rsp_data, rsp_last, e.a, e.d, e.l);
                        end
                    end
                    got++;
                    last_cyc = cyc;
                end else begin
                    held = 1;
                    hv = {rsp_addr, rsp_data, rsp_last};
                end
            end
        end
        if (got < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL rsp_timeout: got %0d responses, want %0d", got, n);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, busy, wr_en,
             wr_reg, wr_data, rd_reg_1, rd_reg_2} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b v=%b a=%0d d=%h l=%b busy=%b we=%b, want all 0",
                     cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, busy, wr_en);
        end
        rst_n = 1;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b, want 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_write_read();
        int f, l;
        wlog.delete();
        send_cmd(2'd1, 5'd5, 32'hDEADBEEF);
        sb.push_back('{a: 5'd5, d: 32'hDEADBEEF, l: 1'b1});
        collect(1, 100, 50, f, l);
        exp_rf[5] = 32'hDEADBEEF;
        n_cmp++;
        if (f !== 2) begin
            n_err++;
            $display("FAIL write_latency: got %0d, want 2", f);
        end
        n_cmp++;
        if (wlog.size() != 1 || wlog[0].a !== 5'd5 || wlog[0].d !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL write_pulse: got %0d wr_en cycles, want 1 at x5=deadbeef", wlog.size());
        end
        send_cmd(2'd0, 5'd5, 32'h0);
        sb.push_back('{a: 5'd5, d: exp_rf[5], l: 1'b1});
        collect(1, 100, 50, f, l);
        n_cmp++;
        if (f !== 2) begin
            n_err++;
            $display("FAIL read_latency: got %0d, want 2", f);
        end
    endtask

    task automatic test_x0();
        int f, l;
        send_cmd(2'd1, 5'd0, 32'h12345678);
        sb.push_back('{a: 5'd0, d: 32'h0, l: 1'b1});
        collect(1, 100, 50, f, l);
        send_cmd(2'd0, 5'd0, 32'h0);
        sb.push_back('{a: 5'd0, d: 32'h0, l: 1'b1});
        collect(1, 100, 50, f, l);
    endtask

    task automatic test_fill();
        int f, l;
        for (int i = 1; i < 32; i++) begin
            logic [31:0] v;
            v = i * 32'h11111111;
            send_cmd(2'd1, 5'(i), v);
            sb.push_back('{a: 5'(i), d: v, l: 1'b1});
            collect(1, 100, 50, f, l);
            exp_rf[i] = v;
        end
    endtask

    task automatic test_dump(input int pct);
        int f, l;
        send_cmd(2'd3, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++)
            sb.push_back('{a: 5'(i), d: exp_rf[i], l: (i == 31)});
        collect(32, pct, 5000, f, l);
        if (pct == 100) begin
            n_cmp++;
            if (l !== 64) begin
                n_err++;
                $display("FAIL dump_cycles: got %0d, want 64", l);
            end
        end
    endtask

    task automatic test_clear();
        int f, l;
        bit ok;
        wlog.delete();
        send_cmd(2'd2, 5'd0, 32'h0);
        sb.push_back('{a: 5'd31, d: 32'h0, l: 1'b1});
        collect(1, 100, 100, f, l);
        for (int i = 1; i < 32; i++) exp_rf[i] = 32'h0;
        n_cmp++;
        if (f !== 32) begin
            n_err++;
            $display("FAIL clear_rsp_cycle: got %0d, want 32", f);
        end
        ok = (wlog.size() == 31);
        for (int i = 0; i < wlog.size() && ok; i++)
            if (wlog[i].a !== 5'(i + 1) || wlog[i].d !== 32'h0 || wlog[i].c != wlog[0].c + i)
                ok = 0;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL clear_writes: got %0d wr_en cycles, want 31 consecutive x1..x31=0",
                     wlog.size());
        end
        test_dump(100);
    endtask

    task automatic test_reset_mid_clear();
        test_fill();
        send_cmd(2'd2, 5'd0, 32'h0);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        n_cmp++;
        if (wr_en !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: wr_en=%b rsp_valid=%b busy=%b, want 0/0/0",
                     wr_en, rsp_valid, busy);
        end
        for (int i = 1; i < 10; i++) exp_rf[i] = 32'h0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_ready: cmd_ready=%b, want 1", cmd_ready);
        end
        test_dump(100);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
        test_reset();
        test_write_read();
        test_x0();
        test_fill();
        test_dump(100);
        test_dump(30);
        test_clear();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
